uart_wb_tx_seq: RTL and testbench

- Wishbone master that configures and feeds the simpleuart_wb slave (clock divider, enable, data register) on the housekeeping bus.
- After reset, or on request, it writes CLK_DIV, reads it back to verify, then writes CONFIG to enable the UART.
- It then drains a small byte FIFO into the DATA register, one Wishbone write per byte.
- It absorbs the slave's ack stall while a byte is still shifting out, and bounds every transaction with a timeout.

---
 rtl/uart_wb_pkg.sv | 26 ++
 rtl/uart_tx_fifo.sv | 70 +++++++
 rtl/uart_wb_tx_seq.sv | 222 ++++++++++++++++++++++
 tb/tb_uart_wb_tx_seq.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_wb_pkg.sv
// Shared definitions for the simpleuart_wb configuration/transmit master.
// Register map offsets, select patterns and the sequencer state encoding.
package uart_wb_pkg;

    localparam logic [7:0] UART_CLK_DIV_OFS = 8'h00;
    localparam logic [7:0] UART_DATA_OFS    = 8'h04;
    localparam logic [7:0] UART_CONFIG_OFS  = 8'h08;

    localparam int unsigned CFG_EN_BIT = 0;

    localparam logic [3:0] SEL_WORD = 4'hF;
    localparam logic [3:0] SEL_BYTE = 4'h1;

    typedef enum logic [2:0] {
        StIdle,
        StCfgDiv,
        StCfgRb,
        StCfgEn,
        StTx
    } state_e;

    function automatic logic [31:0] reg_adr(input logic [31:0] base, input logic [7:0] ofs);
        return base | {24'h0, ofs};
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous FIFO with occupancy count; Depth must be a power of two.
module uart_tx_fifo #(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = 8,
    parameter int unsigned CntW  = $clog2(Depth) + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CntW-1:0]  count_o
);

    localparam int unsigned PtrW = $clog2(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // Pointers wrap naturally because Depth is a power of two.
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/uart_wb_tx_seq.sv
// Wishbone master that programs simpleuart_wb (divider, readback, enable)
// and then drains a byte FIFO into its DATA register, one write per byte.
module uart_wb_tx_seq
    import uart_wb_pkg::*;
#(
    parameter logic [31:0]      BASE_ADR    = 32'h2000_0000,
    parameter logic [7:0]       CLK_DIV_OFS = UART_CLK_DIV_OFS,
    parameter logic [7:0]       DATA_OFS    = UART_DATA_OFS,
    parameter logic [7:0]       CONFIG_OFS  = UART_CONFIG_OFS,
    parameter int unsigned      FIFO_DEPTH  = 4,
    parameter int unsigned      TMO_W       = 20,
    parameter logic [TMO_W-1:0] TMO_CYC     = TMO_W'(20'hF_FFFF)
) (
    input  logic        wb_clk_i,
    input  logic        wb_rstn_i,
    input  logic [31:0] div_i,
    input  logic        cfg_req_i,
    input  logic [7:0]  tx_data_i,
    input  logic        tx_valid_i,
    output logic        tx_ready_o,
    output logic        cfg_done_o,
    output logic        busy_o,
    output logic        err_o,
    input  logic        err_clr_i,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    state_e            state_q, state_d;
    logic              cfg_pend_q, cfg_pend_d;
    logic              cfg_done_q, cfg_done_d;
    logic              err_q, err_d;
    logic [31:0]       div_q, div_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d, tmo_inc;
    logic              bus_q, bus_d;
    logic              we_q, we_d;
    logic [3:0]        sel_q, sel_d;
    logic [31:0]       adr_q, adr_d;
    logic [31:0]       dat_q, dat_d;

    logic              launch;
    state_e            launch_st;
    logic              err_set;
    logic              fifo_push, fifo_pop;
    logic              fifo_full, fifo_empty;
    logic [7:0]        fifo_head;
    logic [CNT_W-1:0]  fifo_count;

    assign fifo_push = tx_valid_i & tx_ready_o;
    assign tmo_inc   = tmo_q + TMO_W'(1);

    uart_tx_fifo #(
        .Depth (FIFO_DEPTH),
        .Width (8),
        .CntW  (CNT_W)
    ) u_fifo (
        .clk_i   (wb_clk_i),
        .rst_ni  (wb_rstn_i),
        .push_i  (fifo_push),
        .data_i  (tx_data_i),
        .pop_i   (fifo_pop),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_comb begin
        state_d    = state_q;
        cfg_pend_d = cfg_pend_q;
        cfg_done_d = cfg_done_q;
        div_d      = div_q;
        tmo_d      = tmo_q;
        bus_d      = bus_q;
        we_d       = we_q;
        sel_d      = sel_q;
        adr_d      = adr_q;
        dat_d      = dat_q;
        launch     = 1'b0;
        launch_st  = StIdle;
        err_set    = 1'b0;
        fifo_pop   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (cfg_pend_q) begin
                    launch     = 1'b1;
                    launch_st  = StCfgDiv;
                    cfg_pend_d = 1'b0;
                    cfg_done_d = 1'b0;
                    div_d      = div_i;
                end else if (cfg_done_q && !fifo_empty) begin
                    launch    = 1'b1;
                    launch_st = StTx;
                end
            end
            StCfgDiv, StCfgRb, StCfgEn, StTx: begin
                if (!bus_q) begin
                    // Idle gap cycle between chained accesses; issue now.
                    launch    = 1'b1;
                    launch_st = state_q;
                end else if (wbm_ack_i) begin
                    bus_d   = 1'b0;
                    we_d    = 1'b0;
                    sel_d   = '0;
                    adr_d   = '0;
                    dat_d   = '0;
                    state_d = StIdle;
                    if (state_q == StCfgDiv) begin
                        state_d = StCfgRb;
                    end else if (state_q == StCfgRb) begin
                        if (wbm_dat_i == div_q) begin
                            state_d = StCfgEn;
                        end else begin
                            err_set = 1'b1;
                        end
                    end else if (state_q == StCfgEn) begin
                        cfg_done_d = 1'b1;
                    end else begin
                        fifo_pop = 1'b1;
                    end
                end else if (tmo_inc == TMO_CYC) begin
                    bus_d    = 1'b0;
                    we_d     = 1'b0;
                    sel_d    = '0;
                    adr_d    = '0;
                    dat_d    = '0;
                    err_set  = 1'b1;
                    fifo_pop = (state_q == StTx);
                    state_d  = StIdle;
                end else begin
                    tmo_d = tmo_inc;
                end
            end
            default: state_d = StIdle;
        endcase

        if (launch) begin
            state_d = launch_st;
            bus_d   = 1'b1;
            tmo_d   = '0;
            case (launch_st)
                StCfgDiv: begin
                    we_d  = 1'b1;
                    sel_d = SEL_WORD;
                    adr_d = reg_adr(BASE_ADR, CLK_DIV_OFS);
                    dat_d = div_d;
                end
                StCfgRb: begin
                    we_d  = 1'b0;
                    sel_d = SEL_WORD;
                    adr_d = reg_adr(BASE_ADR, CLK_DIV_OFS);
                    dat_d = '0;
                end
                StCfgEn: begin
                    we_d  = 1'b1;
                    sel_d = SEL_WORD;
                    adr_d = reg_adr(BASE_ADR, CONFIG_OFS);
                    dat_d = '0;
                    dat_d[CFG_EN_BIT] = 1'b1;
                end
                default: begin
                    we_d  = 1'b1;
                    sel_d = SEL_BYTE;
                    adr_d = reg_adr(BASE_ADR, DATA_OFS);
                    dat_d = {24'h0, fifo_head};
                end
            endcase
        end

        cfg_pend_d = cfg_pend_d | cfg_req_i;
        err_d      = err_set | (err_q & ~err_clr_i);
    end

    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) begin
            state_q    <= StIdle;
            cfg_pend_q <= 1'b1;
            cfg_done_q <= 1'b0;
            err_q      <= 1'b0;
            div_q      <= '0;
            tmo_q      <= '0;
            bus_q      <= 1'b0;
            we_q       <= 1'b0;
            sel_q      <= '0;
            adr_q      <= '0;
            dat_q      <= '0;
        end else begin
            state_q    <= state_d;
            cfg_pend_q <= cfg_pend_d;
            cfg_done_q <= cfg_done_d;
            err_q      <= err_d;
            div_q      <= div_d;
            tmo_q      <= tmo_d;
            bus_q      <= bus_d;
            we_q       <= we_d;
            sel_q      <= sel_d;
            adr_q      <= adr_d;
            dat_q      <= dat_d;
        end
    end

    assign wbm_cyc_o  = bus_q;
    assign wbm_stb_o  = bus_q;
    assign wbm_we_o   = we_q;
    assign wbm_sel_o  = sel_q;
    assign wbm_adr_o  = adr_q;
    assign wbm_dat_o  = dat_q;
    assign cfg_done_o = cfg_done_q;
    assign err_o      = err_q;
    assign tx_ready_o = ~fifo_full;
    assign busy_o     = (state_q != StIdle) | (|fifo_count);

endmodule

// File: tb/tb_uart_wb_tx_seq.sv
// Bench for uart_wb_tx_seq: Wishbone slave model with stall/no-ack/bad-readback
// modes and a scoreboard of expected bus accesses.
module tb_uart_wb_tx_seq;

    localparam logic [31:0] BASE = 32'h2000_0000;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [31:0] div = 32'h3;
    logic        cfg_req = 1'b0;
    logic [7:0]  tx_data = 8'h0;
    logic        tx_valid = 1'b0;
    logic        err_clr = 1'b0;
    logic        tx_ready, cfg_done, busy, err;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, dat_o, dat_i;
    logic        ack;

    always #5 clk = ~clk;

    uart_wb_tx_seq #(
        .TMO_W   (20),
        .TMO_CYC (20'd16)
    ) dut (
        .wb_clk_i   (clk),
        .wb_rstn_i  (rstn),
        .div_i      (div),
        .cfg_req_i  (cfg_req),
        .tx_data_i  (tx_data),
        .tx_valid_i (tx_valid),
        .tx_ready_o (tx_ready),
        .cfg_done_o (cfg_done),
        .busy_o     (busy),
        .err_o      (err),
        .err_clr_i  (err_clr),
        .wbm_cyc_o  (cyc),
        .wbm_stb_o  (stb),
        .wbm_we_o   (we),
        .wbm_sel_o  (sel),
        .wbm_adr_o  (adr),
        .wbm_dat_o  (dat_o),
        .wbm_dat_i  (dat_i),
        .wbm_ack_i  (ack)
    );

    typedef struct packed {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
    } acc_t;

    typedef struct {
        logic [7:0] data;
        logic       ready_after;
    } push_vec_t;

    acc_t exp_q[$];
    int   n_chk = 0;
    int   n_fail = 0;

    int          stall = 0;
    bit          never_ack = 1'b0;
    bit          rb_bad = 1'b0;
    int          wait_cnt;
    logic [31:0] div_reg;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] want);
        n_chk++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, want);
        end
    endtask

    // Slave: registered ack after 'stall' wait cycles; stores the divider.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ack      <= 1'b0;
            wait_cnt <= 0;
            div_reg  <= '0;
        end else begin
            ack <= 1'b0;
            if (cyc && stb && !ack && !never_ack) begin
                if (wait_cnt < stall) begin
                    wait_cnt <= wait_cnt + 1;
                end else begin
                    ack      <= 1'b1;
                    wait_cnt <= 0;
                    if (we && adr == BASE) div_reg <= dat_o;
                end
            end else begin
                wait_cnt <= 0;
            end
        end
    end

    assign dat_i = rb_bad ? 32'h0000_0002 : div_reg;

    always @(negedge clk) begin : monitor
        acc_t got;
        if (rstn && cyc && stb && ack) begin
            got = '{we: we, adr: adr, dat: dat_o, sel: sel};
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_access: got %0h, expected none", got);
            end else begin
                check("bus_access", got, exp_q.pop_front());
            end
        end
    end

    task automatic exp_cfg(input logic [31:0] d);
        exp_q.push_back('{we: 1'b1, adr: BASE, dat: d, sel: 4'hF});
        exp_q.push_back('{we: 1'b0, adr: BASE, dat: 32'h0, sel: 4'hF});
        exp_q.push_back('{we: 1'b1, adr: BASE | 32'h8, dat: 32'h1, sel: 4'hF});
    endtask

    task automatic exp_tx(input logic [7:0] b);
        exp_q.push_back('{we: 1'b1, adr: BASE | 32'h4, dat: {24'h0, b}, sel: 4'h1});
    endtask

    function automatic bit cond(input int which);
        case (which)
            0:       return cyc;
            1:       return cfg_done;
            2:       return err;
            3:       return !busy;
            4:       return cyc && !we;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_until(input int which, input int bound, input string name);
        int n = 0;
        while (!cond(which) && n < bound) begin
            @(negedge clk);
            n++;
        end
        check(name, cond(which), 1);
    endtask

    task automatic pulse_cfg_req();
        cfg_req = 1'b1;
        @(negedge clk);
        cfg_req = 1'b0;
    endtask

    task automatic pulse_err_clr();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    task automatic push_byte(input logic [7:0] b);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        push_vec_t vecs[4];
        int        n;

        vecs[0] = '{data: 8'h55, ready_after: 1'b1};
        vecs[1] = '{data: 8'hA3, ready_after: 1'b1};
        vecs[2] = '{data: 8'hFF, ready_after: 1'b1};
        vecs[3] = '{data: 8'h00, ready_after: 1'b0};

        // Reset state
        #12;
        check("reset_outputs", {cyc, stb, we, sel, adr, dat_o, cfg_done, err, busy}, 0);
        check("reset_ready", tx_ready, 1);

        // Auto configuration after reset, 1-cycle acks
        exp_cfg(32'h3);
        @(negedge clk);
        rstn = 1'b1;
        wait_until(1, 12, "cfg_done_after_reset");
        check("cfg_err_clean", err, 0);
        check("cfg_queue_empty", exp_q.size(), 0);

        // Bad readback: error, no CONFIG write
        rb_bad = 1'b1;
        exp_q.push_back('{we: 1'b1, adr: BASE, dat: 32'h3, sel: 4'hF});
        exp_q.push_back('{we: 1'b0, adr: BASE, dat: 32'h0, sel: 4'hF});
        pulse_cfg_req();
        wait_until(2, 40, "rb_mismatch_err");
        repeat (10) @(negedge clk);
        check("rb_mismatch_done", cfg_done, 0);
        check("rb_mismatch_no_cfg_write", exp_q.size(), 0);
        pulse_err_clr();
        check("err_cleared", err, 0);
        rb_bad = 1'b0;
        exp_cfg(32'h3);
        pulse_cfg_req();
        wait_until(1, 40, "cfg_done_after_retry");

        // Back-to-back pushes fill the FIFO while the slave stalls
        stall = 3;
        foreach (vecs[i]) begin
            exp_tx(vecs[i].data);
            push_byte(vecs[i].data);
            check($sformatf("ready_after_push%0d", i), tx_ready, vecs[i].ready_after);
        end
        wait_until(3, 200, "drain_idle");
        check("drain_queue_empty", exp_q.size(), 0);
        check("drain_ready", tx_ready, 1);
        check("drain_err_clean", err, 0);

        // Timeout on a silent slave discards the byte, next byte still sent
        stall = 0;
        never_ack = 1'b1;
        exp_tx(8'h22);
        push_byte(8'h11);
        push_byte(8'h22);
        wait_until(0, 10, "tmo_cyc_rise");
        n = 0;
        while (cyc && n < 100) begin
            n++;
            @(negedge clk);
        end
        never_ack = 1'b0;
        check("tmo_cycles", n, 16);
        check("tmo_err", err, 1);
        wait_until(3, 100, "tmo_next_byte_idle");
        check("tmo_queue_empty", exp_q.size(), 0);
        check("tmo_cfg_done_kept", cfg_done, 1);
        pulse_err_clr();

        // Config request during a stalled DATA write
        stall = 6;
        exp_tx(8'h41);
        exp_cfg(32'h3);
        exp_tx(8'h42);
        push_byte(8'h41);
        push_byte(8'h42);
        wait_until(0, 10, "req_tx_started");
        pulse_cfg_req();
        wait_until(3, 300, "req_seq_idle");
        check("req_queue_empty", exp_q.size(), 0);
        check("req_cfg_done", cfg_done, 1);
        check("req_err_clean", err, 0);

        // Reset asserted during the readback access
        stall = 5;
        div = 32'h0000_0007;
        exp_q.push_back('{we: 1'b1, adr: BASE, dat: 32'h7, sel: 4'hF});
        pulse_cfg_req();
        wait_until(4, 50, "rst_rb_reached");
        #2;
        rstn = 1'b0;
        #1;
        check("rst_async_bus", {cyc, stb, we, sel, adr, dat_o, cfg_done, err, busy}, 0);
        check("rst_async_ready", tx_ready, 1);
        check("rst_queue", exp_q.size(), 0);
        exp_cfg(32'h7);
        @(negedge clk);
        rstn = 1'b1;
        wait_until(1, 100, "rst_restart_done");
        check("final_queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
